// File: rtl/hyperbus_pkg.sv
// Shared HyperBus transaction/data channel types and FSM state encoding.
// Struct field widths are fixed here; arbiter parameters must agree with them.
package hyperbus_pkg;

   localparam int HB_BURST_WIDTH = 12;
   localparam int HB_NR_CS       = 2;

   typedef struct packed {
      logic [HB_NR_CS-1:0]       cs;
      logic                      write;
      logic [HB_BURST_WIDTH-1:0] burst;
      logic                      burst_type;
      logic                      address_space;
      logic [31:0]               address;
   } trans_t;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  strb;
   } tx_t;

   typedef struct packed {
      logic        last;
      logic        error;
      logic [15:0] data;
   } rx_t;

   typedef struct packed {
      logic last;
      logic error;
   } b_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_READ,
      ST_WRITE
   } arb_state_e;

endpackage

// File: rtl/hyperbus_rr_sel.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping modulo NR_REQ.
module hyperbus_rr_sel #(
   parameter int NR_REQ = 2
) (
   input  logic [NR_REQ-1:0]         req,
   input  logic [$clog2(NR_REQ)-1:0] ptr,
   output logic [$clog2(NR_REQ)-1:0] idx,
   output logic                      any
);

   localparam int IDX_W = $clog2(NR_REQ);

   logic [IDX_W-1:0] cand;

   // Scan from the farthest offset down so the nearest hit to ptr wins.
   always_comb begin
      idx  = '0;
      cand = '0;
      for (int i = NR_REQ - 1; i >= 0; i--) begin
         cand = IDX_W'((int'(ptr) + i) % NR_REQ);
         if (req[cand]) idx = cand;
      end
   end

   assign any = |req;

endmodule

// File: rtl/hyperbus_trans_arbiter.sv
// Arbitrates NR_REQ requesters onto one HyperBus PHY; the grant is held from
// transaction issue until the write response or last read beat.
module hyperbus_trans_arbiter
   import hyperbus_pkg::*;
#(
   parameter int NR_REQ      = 2,
   parameter int BURST_WIDTH = HB_BURST_WIDTH,
   parameter int NR_CS       = HB_NR_CS
) (
   input  logic                      clk_i,
   input  logic                      rst_i,

   input  logic   [NR_REQ-1:0]       req_trans_valid_i,
   output logic   [NR_REQ-1:0]       req_trans_ready_o,
   input  trans_t [NR_REQ-1:0]       req_trans_i,

   input  logic   [NR_REQ-1:0]       req_tx_valid_i,
   output logic   [NR_REQ-1:0]       req_tx_ready_o,
   input  tx_t    [NR_REQ-1:0]       req_tx_i,

   output logic   [NR_REQ-1:0]       req_rx_valid_o,
   input  logic   [NR_REQ-1:0]       req_rx_ready_i,
   output rx_t                       req_rx_o,

   output logic   [NR_REQ-1:0]       req_b_valid_o,
   output b_t                        req_b_o,

   output logic                      phy_trans_valid_o,
   input  logic                      phy_trans_ready_i,
   output trans_t                    phy_trans_o,

   output logic                      phy_tx_valid_o,
   input  logic                      phy_tx_ready_i,
   output tx_t                       phy_tx_o,

   input  logic                      phy_rx_valid_i,
   output logic                      phy_rx_ready_o,
   input  rx_t                       phy_rx_i,

   input  logic                      phy_b_valid_i,
   input  b_t                        phy_b_i,

   output logic [$clog2(NR_REQ)-1:0] grant_o,
   output logic                      busy_o,
   output logic                      err_o
);

   localparam int IDX_W = $clog2(NR_REQ);

   if (BURST_WIDTH != HB_BURST_WIDTH || NR_CS != HB_NR_CS || NR_REQ < 2 || NR_REQ > 8)
   begin : g_bad_cfg
      $error("hyperbus_trans_arbiter: parameters disagree with hyperbus_pkg or NR_REQ out of 2..8");
   end

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] sel_idx, next_ptr;
   logic             sel_any;
   logic             err_q, err_d;

   hyperbus_rr_sel #(.NR_REQ(NR_REQ)) u_rr_sel (
      .req (req_trans_valid_i),
      .ptr (rr_ptr_q),
      .idx (sel_idx),
      .any (sel_any)
   );

   assign next_ptr = (grant_q == IDX_W'(NR_REQ - 1)) ? '0 : grant_q + 1'b1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      grant_d           = grant_q;
      rr_ptr_d          = rr_ptr_q;
      err_d             = err_q;
      req_trans_ready_o = '0;
      req_tx_ready_o    = '0;
      req_rx_valid_o    = '0;
      req_b_valid_o     = '0;
      phy_trans_valid_o = 1'b0;
      phy_tx_valid_o    = 1'b0;
      // Stray read data is swallowed rather than left to stall the PHY.
      phy_rx_ready_o    = phy_rx_valid_i;

      case (state_q)
         ST_IDLE: begin
            if (sel_any) begin
               grant_d = sel_idx;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            phy_trans_valid_o          = req_trans_valid_i[grant_q];
            req_trans_ready_o[grant_q] = phy_trans_ready_i;
            if (!req_trans_valid_i[grant_q]) err_d = 1'b1;
            if (req_trans_valid_i[grant_q] && phy_trans_ready_i)
               state_d = req_trans_i[grant_q].write ? ST_WRITE : ST_READ;
         end
         ST_WRITE: begin
            phy_tx_valid_o          = req_tx_valid_i[grant_q];
            req_tx_ready_o[grant_q] = phy_tx_ready_i;
            if (phy_b_valid_i) begin
               req_b_valid_o[grant_q] = 1'b1;
               state_d                = ST_IDLE;
               rr_ptr_d               = next_ptr;
            end
         end
         ST_READ: begin
            req_rx_valid_o[grant_q] = phy_rx_valid_i;
            phy_rx_ready_o          = req_rx_ready_i[grant_q];
            if (phy_rx_valid_i && req_rx_ready_i[grant_q] && phy_rx_i.last) begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_ptr;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (phy_b_valid_i && state_q != ST_WRITE) err_d = 1'b1;
      if (phy_rx_valid_i && state_q != ST_READ) err_d = 1'b1;
   end

   assign phy_trans_o = req_trans_i[grant_q];
   assign phy_tx_o    = req_tx_i[grant_q];
   assign req_rx_o    = phy_rx_i;
   assign req_b_o     = phy_b_i;
   assign grant_o     = grant_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign err_o       = err_q;

endmodule
